// File: rtl/dff_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared-register arbiter.
// The helper works on a fixed 8-wide vector; callers zero the unused upper requesters.
package dff_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int ARB_MAX = 8;
   localparam int ARB_PW  = 3;

   typedef struct packed {
      logic               found;
      logic [ARB_MAX-1:0] onehot;
   } rr_pick_t;

   // Scan upward from ptr with wrap. Upper bits of req_vec beyond NREQ are zero,
   // so wrapping modulo ARB_MAX visits requesters in the same order as modulo NREQ.
   function automatic rr_pick_t rr_pick(input logic [ARB_MAX-1:0] req_vec,
                                        input logic [ARB_PW-1:0]  ptr,
                                        input logic [ARB_MAX-1:0] excl);
      rr_pick_t           r;
      logic [ARB_MAX-1:0] cand;
      logic [ARB_PW-1:0]  idx;
      r    = '0;
      cand = req_vec & ~excl;
      for (int i = 0; i < ARB_MAX; i++) begin
         idx = ptr + ARB_PW'(i);
         if (!r.found && cand[idx]) begin
            r.found       = 1'b1;
            r.onehot[idx] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dff_bank_reg.sv
// WIDTH-bit enable flop bank with asynchronous active-low clear.
module dff_bank_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else if (en)  q <= d;
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a shared register, with bounded locked bursts.
// The FSM state is kept in the signal 'state' so checkers can bind to it.
module dff_bank_arbiter
   import dff_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic [WIDTH-1:0]        q
);

   localparam int OW = $clog2(NREQ);

   // Handshake: req is a level held with stable wdata until the owner's write edge;
   // gnt rises one edge after req, the write lands on the following edge, and a
   // low req[owner] at that edge abandons the grant without writing.

   arb_state_e          state, state_d;
   logic [NREQ-1:0]     gnt_d;
   logic [OW-1:0]       owner_d, rr_ptr, rr_ptr_d, rel_ptr;
   logic                busy_d;
   logic [3:0]          hold_cnt, hold_cnt_d;
   logic                req_own, lock_own, wr_en, stay;
   logic [WIDTH-1:0]    wr_data;
   logic [ARB_MAX-1:0]  req_ext, excl;
   rr_pick_t            pick;
   logic [OW-1:0]       pick_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         owner    <= owner_d;
         busy     <= busy_d;
         rr_ptr   <= rr_ptr_d;
         hold_cnt <= hold_cnt_d;
      end
   end

   // Owner decode, write strobe and the candidate for the next grant.
   always_comb begin
      req_own  = 1'b0;
      lock_own = 1'b0;
      wr_data  = '0;
      excl     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == OW'(i)) begin
            req_own  = req[i];
            lock_own = lock[i];
            wr_data  = wdata[i*WIDTH +: WIDTH];
            excl[i]  = (state == OWNED);
         end
      end
      wr_en   = (state == OWNED) && req_own;
      stay    = wr_en && lock_own && (int'(hold_cnt) + 1 < MAX_HOLD);
      rel_ptr = (owner == OW'(NREQ-1)) ? '0 : owner + OW'(1);
      req_ext = '0;
      req_ext[NREQ-1:0] = req;
      pick = rr_pick(req_ext, ARB_PW'((state == OWNED) ? rel_ptr : rr_ptr), excl);
      pick_idx = '0;
      for (int i = 0; i < ARB_MAX; i++) begin
         if (pick.onehot[i]) pick_idx = OW'(i);
      end
   end

   always_comb begin
      state_d    = state;
      gnt_d      = gnt;
      owner_d    = owner;
      busy_d     = busy;
      rr_ptr_d   = rr_ptr;
      hold_cnt_d = hold_cnt;
      if (wr_en) hold_cnt_d = hold_cnt + 4'd1;
      if (state == IDLE || !stay) begin
         if (state == OWNED) rr_ptr_d = rel_ptr;
         if (pick.found) begin
            state_d    = OWNED;
            gnt_d      = pick.onehot[NREQ-1:0];
            owner_d    = pick_idx;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      end
   end

   dff_bank_reg #(.WIDTH(WIDTH)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_en),
      .d       (wr_data),
      .q       (q)
   );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_dff_bank_arbiter;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ-1:0]       lock = '0;
   logic [NREQ*WIDTH-1:0] wdata = '0;
   logic [NREQ-1:0]       gnt;
   logic [1:0]            owner;
   logic                  busy;
   logic [WIDTH-1:0]      q;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   int               m_owner, m_ptr, m_hold;
   bit               m_busy;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] exp_q[$];

   dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .lock    (lock),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .q       (q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_w(input int i, input logic [WIDTH-1:0] v);
      wdata[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_ptr   = 0;
      m_hold  = 0;
      m_busy  = 1'b0;
      m_q     = '0;
   endtask

   // First requester at or after 'from' (wrapping), looking at 'span' positions.
   task automatic model_grant(input int from, input int span);
      bit found = 1'b0;
      for (int k = 0; k < span; k++) begin
         int c = (from + k) % NREQ;
         if (!found && req[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_busy  = 1'b1;
            m_hold  = 0;
         end
      end
   endtask

   // Outcome of the coming clock edge given the inputs now applied.
   task automatic model_step();
      int o;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         model_grant(m_ptr, NREQ);
      end else begin
         o = m_owner;
         if (req[o]) begin
            m_q = wdata[o*WIDTH +: WIDTH];
            m_hold++;
         end
         if (!(req[o] && lock[o] && m_hold < MAX_HOLD)) begin
            m_ptr  = (o + 1) % NREQ;
            m_busy = 1'b0;
            model_grant(m_ptr, NREQ - 1);
         end
      end
   endtask

   function automatic logic [NREQ-1:0] exp_gnt();
      return m_busy ? NREQ'(1 << m_owner) : '0;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("gnt", 32'(gnt), 32'(exp_gnt()));
         chk("owner", 32'(owner), 32'(m_owner));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("q", 32'(q), 32'(m_q));
      end
   end

   logic [NREQ-1:0] rr_tab[5];

   initial begin
      rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset with every requester asking.
      #1 reset_n = 1'b0;
      model_reset();
      req = 4'b1111;
      set_w(0, 8'h3C); set_w(1, 8'h3D); set_w(2, 8'h3E); set_w(3, 8'h3F);
      check_en = 1'b1;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_q", 32'(q), 32'h0);
      reset_n = 1'b1;
      tick();
      chk("rst_first_gnt", 32'(gnt), 32'b0001);
      tick();
      chk("rst_first_q", 32'(q), 32'h3C);
      req = '0;
      tick();

      // Single request from requester 2, then pointer should sit at 3.
      req = 4'b0100; set_w(2, 8'hA5);
      tick();
      chk("single_gnt", 32'(gnt), 32'b0100);
      tick();
      chk("single_q", 32'(q), 32'hA5);
      chk("single_idle", 32'(gnt), 32'h0);
      req = 4'b1001; set_w(0, 8'h01); set_w(3, 8'h03);
      tick();
      chk("ptr3_gnt", 32'(gnt), 32'b1000);
      req = '0;
      tick();

      // Round robin with everyone requesting, no lock.
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
         set_w(i, 8'hB0 + 8'(i));
         exp_q.push_back(8'hB0 + 8'(i));
      end
      tick();
      chk("rr_gnt0", 32'(gnt), 32'(rr_tab[0]));
      for (int c = 1; c < 5; c++) begin
         tick();
         chk("rr_gnt", 32'(gnt), 32'(rr_tab[c]));
         chk("rr_q", 32'(q), 32'(exp_q.pop_front()));
         chk("rr_busy", 32'(busy), 32'h1);
      end
      req = '0;
      tick();

      // Locked burst from requester 1 with requester 3 waiting.
      req = 4'b1010; lock = 4'b0010; set_w(1, 8'h10); set_w(3, 8'hAA);
      tick();
      chk("lock_gnt", 32'(gnt), 32'b0010);
      for (int k = 0; k < 4; k++) begin
         set_w(1, 8'h10 + 8'(k));
         tick();
         chk("lock_q", 32'(q), 32'(8'h10 + 8'(k)));
         chk("lock_gnt_seq", 32'(gnt), (k < 3) ? 32'b0010 : 32'b1000);
      end
      set_w(1, 8'h14); req = 4'b1000; lock = '0;
      tick();
      chk("lock_next_q", 32'(q), 32'hAA);
      chk("lock_next_idle", 32'(gnt), 32'h0);
      req = '0;

      // Abandoned grant.
      req = 4'b0001; set_w(0, 8'h77);
      tick();
      chk("aband_gnt", 32'(gnt), 32'b0001);
      req = '0;
      tick();
      chk("aband_q", 32'(q), 32'hAA);
      chk("aband_gnt_off", 32'(gnt), 32'h0);

      // Reset in the middle of a locked burst.
      req = 4'b0100; lock = 4'b0100; set_w(2, 8'h55);
      tick();
      chk("mid_gnt", 32'(gnt), 32'b0100);
      tick();
      chk("mid_q", 32'(q), 32'h55);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_q", 32'(q), 32'h0);
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      req = '0; lock = '0;
      tick();
      reset_n = 1'b1;
      tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            lock[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) set_w(i, 8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            model_reset();
            #1 reset_n = 1'b1;
         end
         tick();
      end

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register. It sits in front of the register and lets NREQ requesters take turns writing it. A requester may lock ownership for a bounded burst of consecutive writes. The held value and the current owner are visible to all requesters.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: width of the shared register
- MAX_HOLD, 4: maximum consecutive writes per grant when locked (1..15)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset; clk is the only clock
- req  input  NREQ  per-requester write request; level, held until granted
- lock  input  NREQ  per-requester burst request; valid only with req
- wdata  input  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant; all-zero when idle
- owner  output  $clog2(NREQ)  index of the granted requester; holds the last owner when idle
- busy  output  1  high while a grant is active (equals |gnt)
- q  output  WIDTH  shared register contents

## Operation
- Reset values: gnt=0, owner=0, busy=0, q=0, rr_ptr=0, hold_cnt=0, state IDLE.
- State IDLE:
  - At a clock edge with any req high, grant the first requester found scanning upward from rr_ptr, with modulo-NREQ wrap.
  - Set gnt, owner and busy; go to OWNED; clear hold_cnt.
  - If no req is high, stay in IDLE.
- State OWNED: at each edge, act on req[owner].
  - If req[owner] is high: q <= wdata[owner] and hold_cnt increments.
  - Stay in OWNED only if req[owner] and lock[owner] are both high and hold_cnt+1 < MAX_HOLD.
  - Otherwise release: rr_ptr <= owner+1 (mod NREQ), then re-arbitrate at the same edge.
  - Re-arbitration on release excludes the releasing owner. If another req is high, grant it with no idle cycle. If not, go to IDLE with gnt=0.
- If req[owner] is low at an edge while OWNED: no write, release as above. This is an abandoned grant.
- Without lock, or with MAX_HOLD=1, each grant performs exactly one write.
- req edges on requesters that are not granted are ignored until arbitration. lock is ignored when its req is low.
- Reset asserted mid-burst: all state clears immediately. Any write pending at the next edge is lost.

## Timing
- Arbitration latency: req high before edge E gives gnt high after E.
- The write happens at edge E+1. q shows the new value after E+1.
- Requesters must keep req and wdata stable from the rising edge of req until the edge where gnt is observed and the write completes.
- Back-to-back grants between different requesters: one write per cycle, no bubble.
- Unlocked fairness: with all NREQ requesters continuously requesting, each receives exactly one grant every NREQ cycles.
- Locked fairness: with lock added, worst-case wait is (NREQ-1)*MAX_HOLD cycles.
- gnt, owner, busy and q are direct flop outputs, with no combinational path from inputs.

## Structure
- Shared package dff_arb_pkg holds the state encoding (IDLE=1'b0, OWNED=1'b1) and the function rr_pick.
  - rr_pick(req_vec, ptr, excl) returns a one-hot vector and a found flag.
- Sub-module dff_bank_reg: WIDTH-bit register with enable.
  - Ports: clk, reset_n, en, d, q.
  - Asynchronous active-low clear to 0.
  - The arbiter drives it with en = OWNED && req[owner] and d = wdata[owner].
- The arbiter FSM, rr_ptr and hold_cnt stay in the top module.

## Test plan
- Reset: hold reset_n=0 with req=4'b1111 → gnt=0, busy=0, q=8'h00. Release reset → gnt=4'b0001 one edge later, q=wdata[0] after the next edge.
- Single request: req[2]=1, wdata[2]=8'hA5, no lock → gnt=4'b0100 for one cycle, q=8'hA5, then gnt=0. Next grant starts scanning from rr_ptr=3.
- Round robin: req=4'b1111 held constantly, no lock → grants 0,1,2,3,0 on consecutive cycles, one write per cycle, busy held high.
- Locked burst: req[1]=lock[1]=1 with data 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, and req[3]=1 pending → exactly 4 writes from requester 1 (q ends 8'h13). Then gnt=4'b1000 with no idle cycle.
- Abandon and mid-op reset:
  - Grant requester 0, then drop req[0] before the write edge → q unchanged, release.
  - Assert reset_n=0 mid-burst → q=0 and gnt=0 asynchronously, before the next clk edge.
